// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch-stage bundle: PC input, imem request/grant/response bus, decode handshake
interface ifetch_unit_if;
  logic [31:0] pc_i;
  logic        redirect_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        fault_o;
  logic        pc_stall_o;

  // Fetch unit side
  modport master (
    input  pc_i, redirect_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fault_o, pc_stall_o
  );

  // PC register / memory / decode side
  modport slave (
    output pc_i, redirect_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fault_o, pc_stall_o
  );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage; optional misalign fault via IFETCH_ALIGN_CHK_EN
module ifetch_unit #(
  parameter logic [31:0] RESET_INST = 32'h0000_0013,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic           clk,
  input logic           rst,
  ifetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fetch_pc_q;
  logic        sample_q;
  logic        drop_q;
  logic [7:0]  cnt_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        fault_q;

  logic [31:0] req_pc;
  logic        misalign;
  logic        timeout_hit;
  logic        drop_now;
  logic        handshake;

  // After a HOLD exit the PC register updates on that same edge, so the
  // first REQ cycle uses the live pc_i rather than a stale registered copy.
  assign req_pc      = sample_q ? bus.pc_i : fetch_pc_q;
  assign timeout_hit = (cnt_q == TO_LAST);
  assign drop_now    = drop_q | bus.redirect_i;
  assign handshake   = (state_q == HOLD) & bus.inst_ready_i;

`ifdef IFETCH_ALIGN_CHK_EN
  assign misalign = (req_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.redirect_i) begin
          state_d = (bus.imem_gnt_i && !misalign) ? WAIT : REQ;
        end else if (misalign) begin
          state_d = HOLD;
        end else if (bus.imem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid_i || timeout_hit) begin
          state_d = drop_now ? REQ : HOLD;
        end
      end
      HOLD: begin
        if (bus.inst_ready_i || bus.redirect_i) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch address, drop flag, timeout counter and held instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= 32'h0;
      sample_q   <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= 8'h0;
      inst_q     <= RESET_INST;
      inst_pc_q  <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fetch_pc_q <= bus.pc_i;
          sample_q   <= 1'b0;
        end
        REQ: begin
          sample_q <= 1'b0;
          if (bus.redirect_i) begin
            fetch_pc_q <= bus.pc_i;
            // A grant coinciding with the redirect still owes us a response
            // that must be swallowed before the next request.
            if (bus.imem_gnt_i && !misalign) begin
              drop_q <= 1'b1;
              cnt_q  <= 8'h0;
            end
          end else begin
            fetch_pc_q <= req_pc;
            if (misalign) begin
              inst_q    <= RESET_INST;
              inst_pc_q <= req_pc;
              fault_q   <= 1'b1;
            end else if (bus.imem_gnt_i) begin
              drop_q <= 1'b0;
              cnt_q  <= 8'h0;
            end
          end
        end
        WAIT: begin
          if (bus.imem_rvalid_i || timeout_hit) begin
            drop_q <= 1'b0;
            if (drop_now) begin
              fetch_pc_q <= bus.pc_i;
            end else if (bus.imem_rvalid_i) begin
              inst_q    <= bus.imem_rdata_i;
              inst_pc_q <= fetch_pc_q;
              fault_q   <= 1'b0;
            end else begin
              inst_q    <= RESET_INST;
              inst_pc_q <= fetch_pc_q;
              fault_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (bus.redirect_i) begin
              drop_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.inst_ready_i || bus.redirect_i) begin
            sample_q <= 1'b1;
          end
        end
        default: begin
          sample_q <= 1'b0;
        end
      endcase
    end
  end

  // Bus request and decode-side handshake outputs
  always_comb begin
    bus.imem_req_o   = 1'b0;
    bus.inst_valid_o = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
    bus.imem_addr_o  = req_pc;
`else
    bus.imem_addr_o  = {req_pc[31:2], 2'b00};
`endif
    if (state_q == REQ) begin
      bus.imem_req_o = !misalign;
    end
    if (state_q == HOLD) begin
      bus.inst_valid_o = 1'b1;
    end
    bus.pc_stall_o = !handshake;
  end

  assign bus.inst_o    = inst_q;
  assign bus.inst_pc_o = inst_pc_q;
  assign bus.fault_o   = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed bench for ifetch_unit
module tb_ifetch_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_INST(32'h0000_0013), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.inst_valid_o), 32'h0);
    chk({tag, "_inst"},  bus.inst_o,            32'h0000_0013);
    chk({tag, "_ipc"},   bus.inst_pc_o,         32'h0);
    chk({tag, "_fault"}, 32'(bus.fault_o),      32'h0);
    chk({tag, "_stall"}, 32'(bus.pc_stall_o),   32'h1);
    chk({tag, "_req"},   32'(bus.imem_req_o),   32'h0);
    chk({tag, "_addr"},  bus.imem_addr_o,       32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.pc_i = 32'h100;
    bus.redirect_i = 1'b0;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = 32'h0;
    bus.inst_ready_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Basic fetch: IDLE -> REQ on the next edge
    tick();
    #1;
    chk("basic_req", 32'(bus.imem_req_o), 32'h1);
    chk("basic_addr", bus.imem_addr_o, 32'h100);
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("basic_wait_noreq", 32'(bus.imem_req_o), 32'h0);
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.inst_ready_i = 1'b1;
    #1;
    chk("basic_valid", 32'(bus.inst_valid_o), 32'h1);
    chk("basic_inst", bus.inst_o, 32'hDEAD_BEEF);
    chk("basic_ipc", bus.inst_pc_o, 32'h100);
    chk("basic_fault", 32'(bus.fault_o), 32'h0);
    chk("basic_stall_hs", 32'(bus.pc_stall_o), 32'h0);
    tick();
    bus.pc_i = 32'h104;
    bus.inst_ready_i = 1'b0;
    #1;
    chk("next_stall", 32'(bus.pc_stall_o), 32'h1);
    chk("next_valid", 32'(bus.inst_valid_o), 32'h0);
    chk("next_req", 32'(bus.imem_req_o), 32'h1);
    chk("next_addr", bus.imem_addr_o, 32'h104);
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'h00A0_0093;
    tick();
    bus.imem_rvalid_i = 1'b0;

    // Backpressure: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(bus.inst_valid_o), 32'h1);
      chk("bp_inst", bus.inst_o, 32'h00A0_0093);
      chk("bp_ipc", bus.inst_pc_o, 32'h104);
      chk("bp_stall", 32'(bus.pc_stall_o), 32'h1);
      chk("bp_noreq", 32'(bus.imem_req_o), 32'h0);
      tick();
    end
    bus.inst_ready_i = 1'b1;
    #1;
    chk("bp_release_stall", 32'(bus.pc_stall_o), 32'h0);
    tick();
    bus.inst_ready_i = 1'b0;
    bus.pc_i = 32'h108;

    // Grant held low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gd_req", 32'(bus.imem_req_o), 32'h1);
      chk("gd_addr", bus.imem_addr_o, 32'h108);
      tick();
    end
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    // Redirect while waiting: response must be dropped
    bus.redirect_i = 1'b1;
    bus.pc_i = 32'h200;
    #1;
    chk("rd_wait_noreq", 32'(bus.imem_req_o), 32'h0);
    tick();
    bus.redirect_i = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'h0000_0BAD;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    chk("rd_drop_valid", 32'(bus.inst_valid_o), 32'h0);
    chk("rd_req", 32'(bus.imem_req_o), 32'h1);
    chk("rd_addr", bus.imem_addr_o, 32'h200);
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'h1234_5678;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    chk("rd_valid", 32'(bus.inst_valid_o), 32'h1);
    chk("rd_inst", bus.inst_o, 32'h1234_5678);
    chk("rd_ipc", bus.inst_pc_o, 32'h200);
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    bus.pc_i = 32'h204;

    // Timeout with TIMEOUT=4: fault visible 5 cycles after the grant cycle
    bus.imem_gnt_i = 1'b1;
    #1;
    chk("to_addr", bus.imem_addr_o, 32'h204);
    tick();
    bus.imem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait_valid", 32'(bus.inst_valid_o), 32'h0);
      chk("to_wait_req", 32'(bus.imem_req_o), 32'h0);
      tick();
    end
    #1;
    chk("to_valid", 32'(bus.inst_valid_o), 32'h1);
    chk("to_fault", 32'(bus.fault_o), 32'h1);
    chk("to_inst", bus.inst_o, 32'h0000_0013);
    chk("to_ipc", bus.inst_pc_o, 32'h204);
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'hFFFF_FFFF;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    chk("late_valid", 32'(bus.inst_valid_o), 32'h1);
    chk("late_inst", bus.inst_o, 32'h0000_0013);
    chk("late_fault", 32'(bus.fault_o), 32'h1);

    // Redirect in HOLD without handshake discards the instruction
    bus.redirect_i = 1'b1;
    bus.pc_i = 32'h300;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("hr_valid", 32'(bus.inst_valid_o), 32'h0);
    chk("hr_addr", bus.imem_addr_o, 32'h300);

    // Misaligned PC
    bus.redirect_i = 1'b1;
    bus.pc_i = 32'h102;
    tick();
    bus.redirect_i = 1'b0;
    #1;
`ifdef IFETCH_ALIGN_CHK_EN
    chk("al_noreq", 32'(bus.imem_req_o), 32'h0);
    tick();
    #1;
    chk("al_valid", 32'(bus.inst_valid_o), 32'h1);
    chk("al_fault", 32'(bus.fault_o), 32'h1);
    chk("al_ipc", bus.inst_pc_o, 32'h102);
    chk("al_inst", bus.inst_o, 32'h0000_0013);
`else
    chk("al_req", 32'(bus.imem_req_o), 32'h1);
    chk("al_addr", bus.imem_addr_o, 32'h100);
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'h0000_0055;
    tick();
    bus.imem_rvalid_i = 1'b0;
    #1;
    chk("al_valid", 32'(bus.inst_valid_o), 32'h1);
    chk("al_fault", 32'(bus.fault_o), 32'h0);
    chk("al_ipc", bus.inst_pc_o, 32'h102);
    chk("al_inst", bus.inst_o, 32'h0000_0055);
`endif
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    bus.pc_i = 32'h400;

    // Asynchronous reset in the middle of WAIT
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 32'hCAFE_F00D;
    tick();
    bus.imem_rvalid_i = 1'b0;
    rst = 1'b0;
    bus.pc_i = 32'h500;
    #1;
    chk("arst_idle_noreq", 32'(bus.imem_req_o), 32'h0);
    chk("arst_idle_inst", bus.inst_o, 32'h0000_0013);
    tick();
    #1;
    chk("arst_restart_req", 32'(bus.imem_req_o), 32'h1);
    chk("arst_restart_addr", bus.imem_addr_o, 32'h500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
